// File: rtl/ysyx_23060236_dcache_wbuf.sv
// Write-back victim buffer for the data cache.
// Evicted dirty lines are queued in a small in-order FIFO and drained one
// by one to memory as single-beat AXI4-Lite writes. Loads can look up the
// queued lines combinationally so a cache miss still sees pending data.
module ysyx_23060236_dcache_wbuf #(
    parameter int ADDR_LEN   = 32,
    parameter int DATA_LEN   = 32,
    parameter int OFFSET_LEN = 2,
    parameter int INDEX_LEN  = 4,
    parameter int TAG_LEN    = ADDR_LEN - OFFSET_LEN - INDEX_LEN,
    parameter int DEPTH      = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    push_valid,
    output logic                    push_ready,
    input  logic [TAG_LEN-1:0]      push_tag,
    input  logic [INDEX_LEN-1:0]    push_index,
    input  logic [DATA_LEN-1:0]     push_data,
    input  logic [ADDR_LEN-1:0]     lookup_addr,
    output logic                    lookup_hit,
    output logic [DATA_LEN-1:0]     lookup_data,
    output logic                    wbuf_empty,
    output logic                    wr_err,
    output logic                    awvalid,
    input  logic                    awready,
    output logic [ADDR_LEN-1:0]     awaddr,
    output logic                    wvalid,
    input  logic                    wready,
    output logic [DATA_LEN-1:0]     wdata,
    output logic [DATA_LEN/8-1:0]   wstrb,
    input  logic                    bvalid,
    output logic                    bready,
    input  logic [1:0]              bresp
);

    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W  = PTR_W + 1;
    localparam int LINE_W = ADDR_LEN - OFFSET_LEN;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        RESP = 2'd2
    } state_e;

    // Entry storage: line address (tag + index) and data, plus valid bits.
    logic [LINE_W-1:0]   line_q [DEPTH];
    logic [LINE_W-1:0]   line_d [DEPTH];
    logic [DATA_LEN-1:0] data_q [DEPTH];
    logic [DATA_LEN-1:0] data_d [DEPTH];
    logic [DEPTH-1:0]    valid_q, valid_d;

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    state_e           state_q, state_d;
    logic             aw_done_q, aw_done_d;
    logic             w_done_q, w_done_d;
    logic             wr_err_q, wr_err_d;
    logic             awvalid_q, awvalid_d;
    logic             wvalid_q, wvalid_d;
    logic             bready_q, bready_d;
    logic             push_ready_q, push_ready_d;
    logic             wbuf_empty_q, wbuf_empty_d;

    logic push_fire_s, pop_fire_s, aw_fire_s, w_fire_s;
    logic lookup_hit_s;
    logic [DATA_LEN-1:0] lookup_data_s;
    logic [PTR_W-1:0]    look_idx_s;
    logic                look_match_s;
    logic                unused_s;

    // Next-state logic: FIFO bookkeeping, drain FSM and registered outputs.
    always_comb begin
        line_d    = line_q;
        data_d    = data_q;
        valid_d   = valid_q;
        head_d    = head_q;
        tail_d    = tail_q;
        state_d   = state_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        wr_err_d  = wr_err_q;

        push_fire_s = push_valid & push_ready_q;
        aw_fire_s   = awvalid_q & awready;
        w_fire_s    = wvalid_q & wready;
        pop_fire_s  = bready_q & bvalid;

        if (push_fire_s) begin
            line_d[tail_q]  = {push_tag, push_index};
            data_d[tail_q]  = push_data;
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + PTR_W'(1);
        end else begin
            tail_d = tail_q;
        end

        if (pop_fire_s) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PTR_W'(1);
            wr_err_d        = wr_err_q | (bresp != 2'b00);
        end else begin
            head_d = head_q;
        end

        // A simultaneous push and pop leaves the occupancy unchanged.
        case ({push_fire_s, pop_fire_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        case (state_q)
            IDLE: begin
                // Looking at count_d lets awvalid rise the cycle after a push.
                if (count_d != '0) begin
                    state_d = SEND;
                end else begin
                    state_d = IDLE;
                end
            end
            SEND: begin
                aw_done_d = aw_done_q | aw_fire_s;
                w_done_d  = w_done_q | w_fire_s;
                if (aw_done_d && w_done_d) begin
                    state_d = RESP;
                end else begin
                    state_d = SEND;
                end
            end
            RESP: begin
                if (pop_fire_s) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = (count_d != '0) ? SEND : IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d   = IDLE;
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
            end
        endcase

        awvalid_d    = (state_d == SEND) & ~aw_done_d;
        wvalid_d     = (state_d == SEND) & ~w_done_d;
        bready_d     = (state_d == RESP);
        push_ready_d = (count_d != FULL_CNT);
        wbuf_empty_d = (count_d == '0) & (state_d == IDLE);
    end

    // Lookup: scan oldest to youngest so the youngest matching entry wins.
    always_comb begin
        lookup_hit_s  = 1'b0;
        lookup_data_s = '0;
        look_idx_s    = head_q;
        look_match_s  = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            look_idx_s    = head_q + PTR_W'(i);
            look_match_s  = valid_q[look_idx_s] &
                            (line_q[look_idx_s] == lookup_addr[ADDR_LEN-1:OFFSET_LEN]);
            lookup_hit_s  = lookup_hit_s | look_match_s;
            lookup_data_s = look_match_s ? data_q[look_idx_s] : lookup_data_s;
        end
    end

    // State register for FIFO, drain FSM and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                line_q[i] <= '0;
                data_q[i] <= '0;
            end
            valid_q      <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            state_q      <= IDLE;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            wr_err_q     <= 1'b0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            bready_q     <= 1'b0;
            push_ready_q <= 1'b1;
            wbuf_empty_q <= 1'b1;
        end else begin
            line_q       <= line_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            state_q      <= state_d;
            aw_done_q    <= aw_done_d;
            w_done_q     <= w_done_d;
            wr_err_q     <= wr_err_d;
            awvalid_q    <= awvalid_d;
            wvalid_q     <= wvalid_d;
            bready_q     <= bready_d;
            push_ready_q <= push_ready_d;
            wbuf_empty_q <= wbuf_empty_d;
        end
    end

    // Byte-offset bits of the lookup address never take part in the compare.
    assign unused_s = ^lookup_addr[OFFSET_LEN-1:0];

    assign push_ready  = push_ready_q;
    assign wbuf_empty  = wbuf_empty_q;
    assign wr_err      = wr_err_q;
    assign awvalid     = awvalid_q;
    assign wvalid      = wvalid_q;
    assign bready      = bready_q;
    assign awaddr      = {line_q[head_q], {OFFSET_LEN{1'b0}}};
    assign wdata       = data_q[head_q];
    assign wstrb       = {(DATA_LEN/8){1'b1}};
    assign lookup_hit  = lookup_hit_s;
    assign lookup_data = lookup_data_s;

endmodule

// File: tb/tb_ysyx_23060236_dcache_wbuf.sv
// Testbench for the write-back victim buffer: a scoreboard queue holds the
// expected (address, data) of each accepted victim and an AXI slave model
// compares every drained write against it in order.
module tb_ysyx_23060236_dcache_wbuf;

    logic        clock;
    logic        reset;
    logic        push_valid;
    logic        push_ready;
    logic [25:0] push_tag;
    logic [3:0]  push_index;
    logic [31:0] push_data;
    logic [31:0] lookup_addr;
    logic        lookup_hit;
    logic [31:0] lookup_data;
    logic        wbuf_empty;
    logic        wr_err;
    logic        awvalid;
    logic        awready;
    logic [31:0] awaddr;
    logic        wvalid;
    logic        wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bvalid;
    logic        bready;
    logic [1:0]  bresp;

    ysyx_23060236_dcache_wbuf dut (
        .clock(clock), .reset(reset),
        .push_valid(push_valid), .push_ready(push_ready),
        .push_tag(push_tag), .push_index(push_index), .push_data(push_data),
        .lookup_addr(lookup_addr), .lookup_hit(lookup_hit), .lookup_data(lookup_data),
        .wbuf_empty(wbuf_empty), .wr_err(wr_err),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bresp(bresp)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int n_cmp = 0;
    int n_bad = 0;
    logic [63:0] exp_q [$];

    // slave knobs and state
    logic        aw_en, w_en, b_en;
    logic [1:0]  bresp_knob;
    int          b_cnt;
    logic        got_aw, got_w;
    logic [31:0] obs_addr, obs_data;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // AXI slave model and write monitor
    initial begin
        logic aw_f, w_f, b_f, rst_s, aw_stall, w_stall;
        logic [31:0] aw_prev, w_prev;
        logic [63:0] e;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        got_aw = 1'b0; got_w = 1'b0; b_cnt = 0;
        obs_addr = 32'h0; obs_data = 32'h0;
        aw_stall = 1'b0; w_stall = 1'b0; aw_prev = 32'h0; w_prev = 32'h0;
        forever begin
            @(negedge clock);
            aw_f  = awvalid & awready;
            w_f   = wvalid & wready;
            b_f   = bvalid & bready;
            rst_s = reset;
            if (!rst_s) begin
                if (awvalid && aw_stall) check_eq("awaddr_stable", awaddr, aw_prev);
                if (wvalid && w_stall)   check_eq("wdata_stable", wdata, w_prev);
                if (bready) check_eq("bready_after_aw_w", 32'(got_aw & got_w), 32'd1);
                if (aw_f) obs_addr = awaddr;
                if (w_f) begin
                    obs_data = wdata;
                    check_eq("wstrb", 32'(wstrb), 32'h0000000F);
                end
                if (b_f) begin
                    check_eq("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check_eq("wr_addr", obs_addr, e[63:32]);
                        check_eq("wr_data", obs_data, e[31:0]);
                    end
                end
            end
            aw_stall = awvalid & ~awready;
            w_stall  = wvalid & ~wready;
            aw_prev  = awaddr;
            w_prev   = wdata;
            @(posedge clock);
            #1;
            if (rst_s) begin
                got_aw = 1'b0; got_w = 1'b0; bvalid = 1'b0; bresp = 2'b00;
                exp_q.delete();
                aw_stall = 1'b0; w_stall = 1'b0;
            end else begin
                if (aw_f) got_aw = 1'b1;
                if (w_f)  got_w  = 1'b1;
                if (b_f) begin
                    bvalid = 1'b0; bresp = 2'b00;
                    got_aw = 1'b0; got_w = 1'b0;
                    b_cnt++;
                end else if (got_aw && got_w && b_en && !bvalid) begin
                    bvalid = 1'b1;
                    bresp  = bresp_knob;
                end
            end
            awready = aw_en;
            wready  = w_en;
        end
    end

    // Offer one victim line; called at posedge+1, returns at posedge+1.
    task automatic push_line(input logic [31:0] addr, input logic [31:0] data, input logic expect_acc);
        push_valid = 1'b1;
        push_tag   = addr[31:6];
        push_index = addr[5:2];
        push_data  = data;
        @(negedge clock);
        check_eq("push_ready", 32'(push_ready), 32'(expect_acc));
        if (push_ready) exp_q.push_back({addr, data});
        @(posedge clock);
        #1;
        push_valid = 1'b0;
    endtask

    task automatic wait_b(input int target);
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (b_cnt >= target) break;
        end
        check_eq("wait_b_timeout", 32'(b_cnt >= target), 32'd1);
    endtask

    task automatic wait_empty();
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            if (wbuf_empty && exp_q.size() == 0) break;
        end
        check_eq("drain_done", 32'(wbuf_empty && exp_q.size() == 0), 32'd1);
    endtask

    initial begin
        int b0;
        reset = 1'b1; push_valid = 1'b0; push_tag = 26'h0; push_index = 4'h0;
        push_data = 32'h0; lookup_addr = 32'h0;
        aw_en = 1'b1; w_en = 1'b1; b_en = 1'b1; bresp_knob = 2'b00;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check_eq("rst_awvalid", 32'(awvalid), 32'd0);
        check_eq("rst_wvalid", 32'(wvalid), 32'd0);
        check_eq("rst_bready", 32'(bready), 32'd0);
        check_eq("rst_push_ready", 32'(push_ready), 32'd1);
        check_eq("rst_empty", 32'(wbuf_empty), 32'd1);
        check_eq("rst_hit", 32'(lookup_hit), 32'd0);
        check_eq("rst_wr_err", 32'(wr_err), 32'd0);

        // single push, immediate drain
        @(posedge clock); #1;
        lookup_addr = 32'h000048D4;
        push_line(32'h000048D4, 32'hDEADBEEF, 1'b1);
        @(negedge clock);
        check_eq("t1_hit", 32'(lookup_hit), 32'd1);
        check_eq("t1_data", lookup_data, 32'hDEADBEEF);
        check_eq("t1_empty_busy", 32'(wbuf_empty), 32'd0);
        wait_empty();
        check_eq("t1_bcnt", 32'(b_cnt), 32'd1);
        check_eq("t1_hit_gone", 32'(lookup_hit), 32'd0);

        // fill with AW stalled, fifth push refused
        @(posedge clock); #1;
        aw_en = 1'b0;
        b0 = b_cnt;
        for (int i = 0; i < 4; i++)
            push_line(32'h10000000 + 32'(i) * 32'h40 + 32'h8, 32'hA0000000 + 32'(i), 1'b1);
        push_line(32'h20000000, 32'hBAD0BAD0, 1'b0);
        check_eq("t2_sb_size", 32'(exp_q.size()), 32'd4);
        @(negedge clock);
        aw_en = 1'b1;
        wait_b(b0 + 1);
        check_eq("t2_ready_after_b", 32'(push_ready), 32'd1);
        wait_empty();

        // AW/W skew: W completes early, AW held off
        @(posedge clock); #1;
        aw_en = 1'b0;
        push_line(32'h30000044, 32'h5A5A5A5A, 1'b1);
        repeat (4) @(negedge clock);
        check_eq("t3_wvalid_low", 32'(wvalid), 32'd0);
        check_eq("t3_awvalid_high", 32'(awvalid), 32'd1);
        check_eq("t3_awaddr", awaddr, 32'h30000044);
        check_eq("t3_bready_low", 32'(bready), 32'd0);
        aw_en = 1'b1;
        wait_empty();

        // duplicate addresses: youngest wins on lookup
        @(posedge clock); #1;
        aw_en = 1'b0;
        lookup_addr = 32'h80000010;
        @(negedge clock);
        check_eq("t4_miss", 32'(lookup_hit), 32'd0);
        @(posedge clock); #1;
        b0 = b_cnt;
        push_line(32'h80000010, 32'h11111111, 1'b1);
        @(negedge clock);
        check_eq("t4_hit_one", 32'(lookup_hit), 32'd1);
        check_eq("t4_data_one", lookup_data, 32'h11111111);
        @(posedge clock); #1;
        push_line(32'h80000010, 32'h22222222, 1'b1);
        @(negedge clock);
        check_eq("t4_hit_two", 32'(lookup_hit), 32'd1);
        check_eq("t4_data_two", lookup_data, 32'h22222222);
        aw_en = 1'b1;
        wait_b(b0 + 1);
        check_eq("t4_hit_after_b1", 32'(lookup_hit), 32'd1);
        check_eq("t4_data_after_b1", lookup_data, 32'h22222222);
        wait_b(b0 + 2);
        check_eq("t4_hit_after_b2", 32'(lookup_hit), 32'd0);
        wait_empty();

        // SLVERR on first write, second drains normally
        check_eq("t5_err_before", 32'(wr_err), 32'd0);
        @(posedge clock); #1;
        aw_en = 1'b0;
        bresp_knob = 2'b10;
        b0 = b_cnt;
        push_line(32'h40000100, 32'hC0DE0001, 1'b1);
        push_line(32'h40000200, 32'hC0DE0002, 1'b1);
        aw_en = 1'b1;
        wait_b(b0 + 1);
        bresp_knob = 2'b00;
        check_eq("t5_err_set", 32'(wr_err), 32'd1);
        wait_empty();
        check_eq("t5_err_sticky", 32'(wr_err), 32'd1);
        check_eq("t5_both_popped", 32'(b_cnt - b0), 32'd2);

        // reset while waiting for B with more entries queued
        @(posedge clock); #1;
        aw_en = 1'b0;
        b_en = 1'b0;
        lookup_addr = 32'h50000008;
        push_line(32'h50000004, 32'hE0000001, 1'b1);
        push_line(32'h50000008, 32'hE0000002, 1'b1);
        push_line(32'h5000000C, 32'hE0000003, 1'b1);
        aw_en = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (bready) break;
        end
        check_eq("t6_in_resp", 32'(bready), 32'd1);
        check_eq("t6_hit_before", 32'(lookup_hit), 32'd1);
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check_eq("t6_bready", 32'(bready), 32'd0);
        check_eq("t6_awvalid", 32'(awvalid), 32'd0);
        check_eq("t6_push_ready", 32'(push_ready), 32'd1);
        check_eq("t6_empty", 32'(wbuf_empty), 32'd1);
        check_eq("t6_hit", 32'(lookup_hit), 32'd0);
        check_eq("t6_wr_err", 32'(wr_err), 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        b_en = 1'b1;
        @(posedge clock); #1;
        push_line(32'h60000010, 32'h0BADF00D, 1'b1);
        wait_empty();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ysyx_23060236_dcache_wbuf.md
Name: ysyx_23060236_dcache_wbuf

Overview:
- Write-back victim buffer on the drain side of the data cache.
- Accepts evicted dirty lines (tag, index, data) at the moment the cache replaces them.
- Queues them in a small in-order FIFO and drains each one to memory as a single-beat AXI4-Lite write.
- Gives the load path a combinational lookup, so a load that misses the cache still sees data that is waiting in the buffer.

Parameters:
- ADDR_LEN, 32, byte address width.
- DATA_LEN, 32, line/word width (one word per line).
- OFFSET_LEN, 2, byte-offset bits; always zero in generated addresses.
- INDEX_LEN, 4, cache index bits.
- TAG_LEN, ADDR_LEN-OFFSET_LEN-INDEX_LEN (26), tag bits.
- DEPTH, 4, number of FIFO entries; must be a power of 2.

Ports:
- clock  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- push_valid  in  1  victim line offered.
- push_ready  out  1  buffer can accept a victim.
- push_tag  in  TAG_LEN  victim tag.
- push_index  in  INDEX_LEN  victim index.
- push_data  in  DATA_LEN  victim data.
- lookup_addr  in  ADDR_LEN  load address to check.
- lookup_hit  out  1  a buffered entry matches lookup_addr.
- lookup_data  out  DATA_LEN  data of the matching entry.
- wbuf_empty  out  1  no entries buffered and no write in flight.
- wr_err  out  1  sticky: some B response was not OKAY.
- awvalid  out  1  AXI write-address valid.
- awready  in  1  AXI write-address ready.
- awaddr  out  ADDR_LEN  AXI write address.
- wvalid  out  1  AXI write-data valid.
- wready  in  1  AXI write-data ready.
- wdata  out  DATA_LEN  AXI write data.
- wstrb  out  DATA_LEN/8  AXI write strobes.
- bvalid  in  1  AXI write-response valid.
- bready  out  1  AXI write-response ready.
- bresp  in  2  AXI write response.

Behaviour:
- Reset values: count=0, head=tail=0, state IDLE, aw_done=w_done=0, wr_err=0. Outputs: awvalid=wvalid=bready=0, push_ready=1, wbuf_empty=1, lookup_hit=0.
- Reset mid-transaction clears all of the above. Any in-flight AXI write is abandoned; memory is reset alongside this block.
- Storage: per-entry valid, addr = {tag, index, OFFSET_LEN'b0}, and data.
- Push:
  - push_ready = (count != DEPTH).
  - Push fires on push_valid & push_ready: write entry[tail], advance tail (wraps modulo DEPTH), count+1.
  - A push and a pop in the same cycle leave count unchanged.
  - When full, push_ready=0 even if a pop occurs that cycle; there is no bypass.
- Drain FSM:
  - IDLE: if count != 0 → SEND. The earliest awvalid is the cycle after the push.
  - SEND:
    - awvalid = ~aw_done; wvalid = ~w_done.
    - awaddr = entry[head].addr; wdata = entry[head].data; wstrb = all ones.
    - AW and W handshakes are independent, in either order or the same cycle. Each sets its done flag.
    - When both are done (counting the current cycle's handshakes) → RESP.
    - awvalid/wvalid, once asserted, stay asserted with stable payload until their handshake.
  - RESP:
    - bready=1. On bvalid: pop head (valid=0, head+1, count-1) and clear aw_done/w_done.
    - If bresp != 2'b00, set wr_err. The entry is still popped; there is no retry.
    - Next state: SEND if count after pop > 0, else IDLE.
- Ordering: strict FIFO. Duplicate addresses are allowed; both entries are written in push order.
- Lookup:
  - Combinational compare of lookup_addr[ADDR_LEN-1:OFFSET_LEN] against every valid entry.
  - If several entries match, the youngest (closest to tail) wins.
  - The head entry stays visible to lookup until its B handshake.
  - An entry pushed in cycle N is visible to lookup from cycle N+1.
  - lookup_data is don't-care when lookup_hit=0.
- wbuf_empty = (count==0) & (state==IDLE). The flush/fence logic waits on it.
- wr_err is cleared only by reset.

Test Plan:
- Single push, tag=0x0000123, index=0x5, data=0xDEADBEEF, awready=wready=1, bvalid one cycle after W:
  - awaddr=0x000048D4, wdata=0xDEADBEEF, wstrb=4'hF.
  - Entry popped on B; wbuf_empty=1 afterwards.
- Push 4 entries with awready held 0:
  - push_ready=0 after the 4th push; a 5th push_valid is not accepted.
  - After one B handshake, push_ready=1 the next cycle.
  - Writes leave in push order.
- AW/W skew:
  - wready asserted 3 cycles before awready → wvalid drops after the W handshake while awvalid holds with stable awaddr.
  - bready rises only after both handshakes.
- Lookup with two entries for address 0x80000010, data 0x11111111 then 0x22222222:
  - lookup_hit=1, lookup_data=0x22222222.
  - After the first B → still 0x22222222; after the second B → lookup_hit=0.
- bresp=2'b10 on the first write → wr_err=1 and stays 1; the entry is popped and the next entry drains normally.
- Reset asserted in RESP with 2 entries queued → the next cycle has bready=0, awvalid=0, push_ready=1, wbuf_empty=1, lookup_hit=0.
